// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: access-type codes, FSM states,
// and the lane-select / extension helpers used by mem_stage.
package mem_pkg;

  localparam logic [2:0] LS_BS = 3'b000;
  localparam logic [2:0] LS_HS = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b011;
  localparam logic [2:0] LS_HU = 3'b100;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  // Codes 101..111 fall through to word.
  function automatic logic [1:0] ls_size(input logic [2:0] t);
    case (t)
      LS_BS, LS_BU: return SZ_B;
      LS_HS, LS_HU: return SZ_H;
      default:      return SZ_W;
    endcase
  endfunction

  function automatic logic ls_unsigned(input logic [2:0] t);
    return (t == LS_BU) || (t == LS_HU);
  endfunction

  function automatic logic [1:0] align_off(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_H:    return {off[1], 1'b0};
      SZ_W:    return 2'b00;
      default: return off;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_rep(input logic [1:0] sz, input logic [31:0] rt);
    case (sz)
      SZ_B:    return {4{rt[7:0]}};
      SZ_H:    return {2{rt[15:0]}};
      default: return rt;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0] sz, input logic uns,
                                           input logic [1:0] off, input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (sz)
      SZ_B:    return uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/data_ram.sv
// Word-organised data RAM: synchronous byte-enabled write, asynchronous read.
module data_ram #(
  parameter int DEPTH_W = 10
) (
  input  logic               clk,
  input  logic               we,
  input  logic [3:0]         be,
  input  logic [DEPTH_W-1:0] addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  logic [31:0] mem [0:(1<<DEPTH_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte/half/word loads and stores with WAIT_STATES extra cycles,
// registered into MEM/WB. Optional misalignment trap under MEM_MISALIGN_TRAP_EN.
module mem_stage
  import mem_pkg::*;
#(
  parameter int DEPTH_W     = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_ALU_res,
  input  logic [31:0] i_rt_reg,
  input  logic [31:0] i_pc_to_reg,
  input  logic [4:0]  i_addr_reg_dst,
  input  logic        is_RegWrite,
  input  logic        is_MemtoReg,
  input  logic        is_MemWrite,
  input  logic        is_MemRead,
  input  logic [2:0]  is_load_store_type,
  output logic        o_stall,
  output logic [31:0] o_read_data,
  output logic [31:0] o_ALU_res,
  output logic [31:0] o_pc_to_reg,
  output logic [4:0]  o_addr_reg_dst,
  output logic        os_RegWrite,
  output logic        os_MemtoReg,
  output logic        os_misalign
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic        state;
  logic [3:0]  cnt;
  logic        mem_op;
  logic        mis;
  logic        access;
  logic        we;
  logic [1:0]  sz;
  logic [1:0]  off_raw;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] ld_data;

  logic [31:0] read_data_p1;
  logic [31:0] alu_res_p1;
  logic [31:0] pc_to_reg_p1;
  logic [4:0]  addr_reg_dst_p1;
  logic        reg_write_p1;
  logic        mem_to_reg_p1;
  logic        misalign_p1;

  assign sz      = ls_size(is_load_store_type);
  assign off_raw = i_ALU_res[1:0];
  assign mem_op  = is_MemRead | is_MemWrite;

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = mem_op & misaligned(sz, off_raw);
  assign off = off_raw;
`else
  assign mis = 1'b0;
  assign off = align_off(sz, off_raw);
`endif

  // A trapped access never waits: it completes as a suppressed op in IDLE.
  assign access  = (state == ST_IDLE) ? (!mem_op || (WS == 4'd0) || mis) : (cnt == WS);
  assign o_stall = rst & ((state == ST_IDLE) ? (mem_op && !mis && (WS != 4'd0)) : (cnt < WS));

  // Write is gated by reset so an access interrupted by reset never commits.
  assign we    = rst & access & is_MemWrite & !mis;
  assign be    = lane_be(sz, off);
  assign wdata = store_rep(sz, i_rt_reg);

  data_ram #(.DEPTH_W(DEPTH_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .be    (be),
    .addr  (i_ALU_res[DEPTH_W+1:2]),
    .wdata (wdata),
    .rdata (rdata)
  );

  // Simultaneous read+write is treated as a pure write with zero read data.
  assign ld_data = (is_MemRead && !is_MemWrite && !mis)
                 ? load_ext(sz, ls_unsigned(is_load_store_type), off, rdata)
                 : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else if (state == ST_IDLE) begin
      if (mem_op && !mis && (WS != 4'd0)) begin
        state <= ST_WAIT;
        cnt   <= 4'd1;
      end
    end else if (cnt == WS) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

  // MEM -> WB boundary: result on access, bubble otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data_p1    <= 32'd0;
      alu_res_p1      <= 32'd0;
      pc_to_reg_p1    <= 32'd0;
      addr_reg_dst_p1 <= 5'd0;
      reg_write_p1    <= 1'b0;
      mem_to_reg_p1   <= 1'b0;
      misalign_p1     <= 1'b0;
    end else if (access) begin
      read_data_p1    <= ld_data;
      alu_res_p1      <= i_ALU_res;
      pc_to_reg_p1    <= i_pc_to_reg;
      addr_reg_dst_p1 <= i_addr_reg_dst;
      reg_write_p1    <= is_RegWrite & !mis;
      mem_to_reg_p1   <= is_MemtoReg;
      misalign_p1     <= mis;
    end else begin
      read_data_p1    <= 32'd0;
      alu_res_p1      <= 32'd0;
      pc_to_reg_p1    <= 32'd0;
      addr_reg_dst_p1 <= 5'd0;
      reg_write_p1    <= 1'b0;
      mem_to_reg_p1   <= 1'b0;
      misalign_p1     <= 1'b0;
    end
  end

  assign o_read_data    = read_data_p1;
  assign o_ALU_res      = alu_res_p1;
  assign o_pc_to_reg    = pc_to_reg_p1;
  assign o_addr_reg_dst = addr_reg_dst_p1;
  assign os_RegWrite    = reg_write_p1;
  assign os_MemtoReg    = mem_to_reg_p1;
  assign os_misalign    = misalign_p1;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage sitting directly downstream of the EX/MEM latch and feeding the write-back stage. Consumes the latched ALU result (address), rt store data and control bits. Performs byte/half/word loads and stores against an internal word-organised data RAM with configurable wait states, and registers the result into MEM/WB outputs. Raises a stall toward the hazard unit while a multi-cycle access is outstanding.

## Interface
- DEPTH_W, 10: log2 of RAM depth in 32-bit words.
- WAIT_STATES, 0: extra cycles per memory access, 0..15.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- i_ALU_res  in  32  byte address for loads/stores; passthrough otherwise
- i_rt_reg  in  32  store data
- i_pc_to_reg  in  32  link value for write-back
- i_addr_reg_dst  in  5  destination register
- is_RegWrite, is_MemtoReg, is_MemWrite, is_MemRead  in  1 each  control from EX/MEM
- is_load_store_type  in  3  access size/sign
- o_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- o_read_data  out  32  extended load result
- o_ALU_res, o_pc_to_reg  out  32 each  registered passthrough
- o_addr_reg_dst  out  5  registered passthrough
- os_RegWrite, os_MemtoReg  out  1 each  registered control to WB
- os_misalign  out  1  misaligned access flag (only with MEM_MISALIGN_TRAP_EN)

## Operation
- Type encoding: 000 byte signed, 001 half signed, 010 word, 011 byte unsigned, 100 half unsigned; stores use 000/001/010 (bit 2 and unsigned ignored). 101–111 treated as word.
- Little-endian. Word index = i_ALU_res[DEPTH_W+1:2]; upper address bits ignored (wraps).
- Store: byte lanes selected by size and addr[1:0]; rt's low byte/half replicated into the selected lane; other lanes unchanged.
- Load: selected lane extracted, sign- or zero-extended to 32 bits.
- Mem op = is_MemRead | is_MemWrite. Both set: treated as write only, read data 0.
- FSM states: IDLE, WAIT. Counter cnt, 4 bits.
  - IDLE, no mem op or WAIT_STATES=0: access (if any) performed this cycle; WB registers load at edge.
  - IDLE, mem op, WAIT_STATES>0: o_stall=1, WB registers load bubble (all controls 0, data 0), go WAIT, cnt<=1.
  - WAIT, cnt<WAIT_STATES: o_stall=1, bubble into WB, cnt++.
  - WAIT, cnt==WAIT_STATES: o_stall=0, access performed, WB registers load result, go IDLE.
- o_stall combinational from state, cnt, mem op.

## Timing
- Reset (async, rst=0): state IDLE, cnt 0, all outputs 0, o_stall 0. RAM contents not cleared; an in-flight access is dropped, no write commits.
- Non-memory or zero-wait op: one-cycle latency EX/MEM -> WB outputs; RAM write commits at the same edge.
- Memory op with W wait states: o_stall high exactly W cycles, result on WB outputs W+1 edges after first presentation; exactly one RAM write and one WB update per instruction.
- Back-to-back memory ops: each restarts from IDLE; no bypass cycle between them.
- Load following store to same word: load sees stored data (store committed at earlier edge).

## Configuration
- MEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 is suppressed — no RAM write, o_read_data 0, os_RegWrite 0, os_misalign 1 for that WB cycle, no wait states, no stall.
- Undefined: low address bits forced to zero per size (half clears bit 0, word bits 1:0); access proceeds; os_misalign tied 0.

## Structure
- Package mem_pkg: load/store type localparams, FSM state enum, lane-select/extension functions.
- Sub-module data_ram: 2^DEPTH_W x 32, synchronous write with 4-bit byte enable, asynchronous read; instantiated once.

## Test plan
- W=0: SW 0xDEADBEEF @0x10, then LW @0x10 -> o_read_data 0xDEADBEEF one cycle later, o_stall never high.
- W=0: SB 0x80 @0x13 over word 0 at 0x10, then LB @0x13 -> 0xFFFFFF80; LBU -> 0x00000080; LW @0x10 -> 0x80000000.
- W=3: LW presented -> o_stall high 3 cycles, bubbles (os_RegWrite 0) on WB meanwhile, data valid after 4th edge.
- W=3: rst low during cycle 2 of SW -> outputs 0, state IDLE, later LW returns prior contents.
- MEM_MISALIGN_TRAP_EN: LH @0x11 -> os_misalign 1, os_RegWrite 0, no stall; without macro LH @0x11 returns half at 0x10.
- Non-memory op (RegWrite=1, ALU_res 0x1234) -> o_ALU_res 0x1234, os_RegWrite 1 next cycle, no RAM change.
